// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin denominations, refill codes,
// payout state encoding and drink prices.
package vend_pkg;

    // Coin denominations in dollars.
    localparam int unsigned DEN10 = 10;
    localparam int unsigned DEN5  = 5;
    localparam int unsigned DEN1  = 1;

    // refill_denom encodings; REFILL_NONE is ignored by the dispenser.
    localparam logic [1:0] REFILL_DEN1  = 2'd0;
    localparam logic [1:0] REFILL_DEN5  = 2'd1;
    localparam logic [1:0] REFILL_DEN10 = 2'd2;
    localparam logic [1:0] REFILL_NONE  = 2'd3;

    // Drink prices used by the vending FSM.
    localparam int unsigned PRICE_WATER = 7;
    localparam int unsigned PRICE_SODA  = 12;
    localparam int unsigned PRICE_JUICE = 16;

    // Payout state machine.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_DISP,
        ST_DONE,
        ST_SHORT
    } disp_state_t;

    // Dollar value of a refill/stock index (0 = 1, 1 = 5, 2 = 10).
    function automatic int unsigned denom_value(input logic [1:0] code);
        case (code)
            REFILL_DEN1:  return DEN1;
            REFILL_DEN5:  return DEN5;
            REFILL_DEN10: return DEN10;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake/bus bundle between the vending FSM side (master) and the
// change dispenser (slave).
interface change_dispenser_if #(
    parameter int WIDTH   = 32,
    parameter int STOCK_W = 8
);
    logic               change_valid;
    logic [WIDTH-1:0]   change_in;
    logic               busy;
    logic               coin_valid;
    logic [WIDTH-1:0]   coin_out;
    logic               coin_ready;
    logic               done;
    logic               short;
    logic [WIDTH-1:0]   shortfall;
    logic               abort;
    logic               refill_valid;
    logic [1:0]         refill_denom;
    logic [STOCK_W-1:0] refill_count;
    logic [STOCK_W-1:0] stock10;
    logic [STOCK_W-1:0] stock5;
    logic [STOCK_W-1:0] stock1;

    modport master (
        output change_valid, change_in, coin_ready, abort,
               refill_valid, refill_denom, refill_count,
        input  busy, coin_valid, coin_out, done, short, shortfall,
               stock10, stock5, stock1
    );

    modport slave (
        input  change_valid, change_in, coin_ready, abort,
               refill_valid, refill_denom, refill_count,
        output busy, coin_valid, coin_out, done, short, shortfall,
               stock10, stock5, stock1
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy coin picker: largest denomination that fits in the
// remaining amount and is still in stock.
module coin_select
    import vend_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STOCK_W = 8
) (
    input  logic [WIDTH-1:0]   remaining,
    input  logic [STOCK_W-1:0] stock10,
    input  logic [STOCK_W-1:0] stock5,
    input  logic [STOCK_W-1:0] stock1,
    output logic               found,
    output logic [WIDTH-1:0]   denom
);

    // Priority pick 10, then 5, then 1; an empty tube is skipped.
    always_comb begin
        found = 1'b0;
        denom = '0;
        if (remaining >= WIDTH'(DEN10) && stock10 != '0) begin
            found = 1'b1;
            denom = WIDTH'(DEN10);
        end else if (remaining >= WIDTH'(DEN5) && stock5 != '0) begin
            found = 1'b1;
            denom = WIDTH'(DEN5);
        end else if (remaining >= WIDTH'(DEN1) && stock1 != '0) begin
            found = 1'b1;
            denom = WIDTH'(DEN1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: pays a requested amount one coin at a time to the
// hopper, greedy by denomination, limited by per-denomination stock.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 20,
    parameter int STOCK_MAX  = 255
) (
    input  logic              clk,
    input  logic              reset,
    change_dispenser_if.slave bus
);

    localparam int SUM_W = STOCK_W + 1;

    disp_state_t      state_reg;
    logic [WIDTH-1:0] remaining_reg;
    logic             coin_valid_reg;
    logic [WIDTH-1:0] coin_out_reg;
    logic             done_reg;
    logic             short_reg;
    logic [WIDTH-1:0] shortfall_reg;

    logic             sel_found;
    logic [WIDTH-1:0] sel_denom;
    logic             handshake;
    logic [WIDTH-1:0] remaining_next;

    // A coin leaves only in DISP with both sides agreeing.
    assign handshake      = (state_reg == ST_DISP) && coin_valid_reg && bus.coin_ready;
    // Cannot wrap: the offered coin was chosen with coin <= remaining.
    assign remaining_next = remaining_reg - coin_out_reg;

    // Stock counters, indexed by refill code (0 = 1, 1 = 5, 2 = 10).
    for (genvar gi = 0; gi < 3; gi++) begin : g_stock
        localparam int unsigned DEN_VAL = denom_value(2'(gi));

        logic [STOCK_W-1:0] stock_reg;
        logic               dec;
        logic               refill_hit;
        logic [SUM_W-1:0]   stock_next;

        assign dec        = handshake && (coin_out_reg == WIDTH'(DEN_VAL));
        assign refill_hit = bus.refill_valid && (bus.refill_denom == 2'(gi));
        // The dispensed coin is removed before the refill is added, then
        // the sum saturates; one extra bit holds the pre-saturation value.
        assign stock_next = {1'b0, stock_reg} - SUM_W'(dec)
                          + (refill_hit ? {1'b0, bus.refill_count} : SUM_W'(0));

        // Update stock from same-cycle dispense and refill.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stock_reg <= STOCK_W'(INIT_STOCK);
            end else if (stock_next > SUM_W'(STOCK_MAX)) begin
                stock_reg <= STOCK_W'(STOCK_MAX);
            end else begin
                stock_reg <= stock_next[STOCK_W-1:0];
            end
        end
    end

    coin_select #(
        .WIDTH   (WIDTH),
        .STOCK_W (STOCK_W)
    ) u_coin_select (
        .remaining (remaining_reg),
        .stock10   (g_stock[2].stock_reg),
        .stock5    (g_stock[1].stock_reg),
        .stock1    (g_stock[0].stock_reg),
        .found     (sel_found),
        .denom     (sel_denom)
    );

    // Payout sequencing with registered coin offer and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            remaining_reg  <= '0;
            coin_valid_reg <= 1'b0;
            coin_out_reg   <= '0;
            done_reg       <= 1'b0;
            short_reg      <= 1'b0;
            shortfall_reg  <= '0;
        end else begin
            done_reg      <= 1'b0;
            short_reg     <= 1'b0;
            shortfall_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.change_valid) begin
                        remaining_reg <= bus.change_in;
                        state_reg     <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (bus.abort) begin
                        short_reg     <= 1'b1;
                        shortfall_reg <= remaining_reg;
                        state_reg     <= ST_SHORT;
                    end else if (remaining_reg == '0) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (sel_found) begin
                        coin_valid_reg <= 1'b1;
                        coin_out_reg   <= sel_denom;
                        state_reg      <= ST_DISP;
                    end else begin
                        short_reg     <= 1'b1;
                        shortfall_reg <= remaining_reg;
                        state_reg     <= ST_SHORT;
                    end
                end
                ST_DISP: begin
                    if (handshake) begin
                        remaining_reg <= remaining_next;
                    end
                    if (bus.abort) begin
                        // A coin accepted in the abort cycle still counts.
                        coin_valid_reg <= 1'b0;
                        coin_out_reg   <= '0;
                        short_reg      <= 1'b1;
                        shortfall_reg  <= handshake ? remaining_next : remaining_reg;
                        state_reg      <= ST_SHORT;
                    end else if (handshake) begin
                        coin_valid_reg <= 1'b0;
                        coin_out_reg   <= '0;
                        state_reg      <= ST_SEL;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                ST_SHORT: begin
                    remaining_reg <= '0;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.coin_valid = coin_valid_reg;
    assign bus.coin_out   = coin_out_reg;
    assign bus.done       = done_reg;
    assign bus.short      = short_reg;
    assign bus.shortfall  = shortfall_reg;
    assign bus.stock1     = g_stock[0].stock_reg;
    assign bus.stock5     = g_stock[1].stock_reg;
    assign bus.stock10    = g_stock[2].stock_reg;

endmodule
